// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch channel: req/addr out from the fetch unit, ack/rdata back from memory.
interface pc_fetch_unit_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned ILEN = 32;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [ILEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer: picks the next PC from jump/branch
// redirects, fetches over a req/ack handshake and presents one instruction at a time.
module pc_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            stall,
    pc_fetch_unit_if.master imem,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned_trap
);
    localparam int unsigned ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
    localparam logic [XLEN-1:0] JMP_MASK  = ~XLEN'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_TRAP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic [ILEN-1:0] instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            trap_q, trap_d;
    logic [XLEN-1:0] next_pc_c;
    logic            req_c;

    // Redirect priority: jump beats branch beats sequential.
    always_comb begin
        next_pc_c = pc_plus4_q;
        if (jump) begin
            next_pc_c = jump_target & JMP_MASK;
        end else if (branch_taken) begin
            next_pc_c = branch_target;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        trap_d     = trap_q;
        req_c      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                req_c = 1'b1;
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    valid_d = 1'b1;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (!stall) begin
                    valid_d = 1'b0;
                    if (next_pc_c[1:0] == 2'b00) begin
                        pc_d       = next_pc_c;
                        pc_plus4_d = next_pc_c + PC_STEP;
                        state_d    = S_FETCH;
                    end else begin
                        // Misaligned target: freeze the PC and halt until reset.
                        trap_d  = 1'b1;
                        state_d = S_TRAP;
                    end
                end
            end
            S_TRAP: begin
                valid_d = 1'b0;
                trap_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            pc_plus4_q <= RESET_PC + PC_STEP;
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            trap_q     <= trap_d;
        end
    end

    // Fetch request and address decode straight from state and PC.
    assign imem.imem_req  = req_c;
    assign imem.imem_addr = pc_q;

    assign instr_valid     = valid_q;
    assign instr           = instr_q;
    assign pc              = pc_q;
    assign pc_plus4        = pc_plus4_q;
    assign misaligned_trap = trap_q;
endmodule
